// File: rtl/tc_timer_pkg.sv
`default_nettype none
// ============================================================================
// tc_timer_pkg : shared state encodings, register offsets and CTRL fields
//                for the memory-mapped countdown timer.
// Revision     : 1.0
// ============================================================================
package tc_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_W        = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Codes 1x fall back to one-shot, so only the exact auto-reload code reloads.
  function automatic logic is_auto(input logic [CTRL_W-1:0] ctrl);
    return (ctrl[CTRL_MODE_LSB +: 2] == MODE_AUTO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_bus_if.sv
`default_nettype none
// ============================================================================
// tc_bus_if : address decode, byte-lane write merge and read mux for tc_timer.
//             Byte-lane writes are enabled by defining TC_BYTE_WRITE_EN.
// Revision  : 1.0
// ============================================================================
module tc_bus_if
  import tc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [31:0]       preset,
  input  logic [31:0]       count,
  output logic              hit,
  output logic [31:0]       rdata,
  output logic              wr_ctrl,
  output logic              wr_preset,
  output logic [CTRL_W-1:0] ctrl_wdata,
  output logic [31:0]       preset_wdata
);

  logic [1:0] sel;
  logic       wr_any;
  logic       unused_addr_bits;

  assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel              = addr[3:2];
  assign wr_any           = we & hit & (byteen != 4'b0000);
  assign wr_ctrl          = wr_any & (sel == REG_CTRL);
  assign wr_preset        = wr_any & (sel == REG_PRESET);
  assign unused_addr_bits = ^addr[1:0];

`ifdef TC_BYTE_WRITE_EN
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign preset_wdata[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : preset[8*i +: 8];
  end
  // All implemented CTRL bits live in lane 0.
  assign ctrl_wdata = byteen[0] ? wdata[CTRL_W-1:0] : ctrl;
`else
  assign preset_wdata = wdata;
  assign ctrl_wdata   = wdata[CTRL_W-1:0];
`endif

  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (sel)
        REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl};
        REG_PRESET: rdata = preset;
        REG_COUNT:  rdata = count;
        default:    rdata = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
// tc_timer : memory-mapped countdown timer with one-shot / auto-reload modes
//            and a maskable interrupt. Optional macro: TC_BYTE_WRITE_EN.
// Revision : 1.0
// ============================================================================
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              pending_q, pending_d;

  logic              wr_ctrl, wr_preset;
  logic [CTRL_W-1:0] ctrl_wdata;
  logic [31:0]       preset_wdata;

  tc_bus_if #(
    .BASE_ADDR (BASE_ADDR)
  ) u_bus_if (
    .addr         (addr),
    .we           (we),
    .byteen       (byteen),
    .wdata        (wdata),
    .ctrl         (ctrl_q),
    .preset       (preset_q),
    .count        (count_q),
    .hit          (hit),
    .rdata        (rdata),
    .wr_ctrl      (wr_ctrl),
    .wr_preset    (wr_preset),
    .ctrl_wdata   (ctrl_wdata),
    .preset_wdata (preset_wdata)
  );

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    // Hardware EN clear first so a same-cycle software CTRL write overrides it.
    if (state_q == ST_INT && !is_auto(ctrl_q)) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl)   ctrl_d   = ctrl_wdata;
    if (wr_preset) preset_d = preset_wdata;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_d[CTRL_EN]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d   = preset_q;
        pending_d = 1'b0;
        state_d   = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_d[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        pending_d = 1'b1;
        state_d   = is_auto(ctrl_q) ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ctrl) pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      preset_q  <= 32'h0;
      count_q   <= 32'h0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign irq = pending_q & ctrl_q[CTRL_IM];

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_tc_timer : scoreboard bench for tc_timer; stimulus queues expected
//               {rdata, hit, irq} and a negedge monitor pops and compares.
// Revision    : 1.0
// ============================================================================
module tb_tc_timer;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV    = BASE + 32'hC;

`ifdef TC_BYTE_WRITE_EN
  localparam logic [31:0] EXP_LANE_PRESET = 32'h11BB_3344;
  localparam logic [31:0] EXP_LANE_CTRL   = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_LANE_PRESET = 32'hAABB_CCDD;
  localparam logic [31:0] EXP_LANE_CTRL   = 32'h0000_0008;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  typedef struct packed {
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  logic  smp = 1'b0;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  tc_timer #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  always @(negedge clk) begin
    if (smp) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample: got rdata=%h hit=%b irq=%b, no expectation queued",
                 rdata, hit, irq);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if ({rdata, hit, irq} !== mon_e) begin
          failures++;
          $display("FAIL %s: got rdata=%h hit=%b irq=%b, want rdata=%h hit=%b irq=%b",
                   mon_n, rdata, hit, irq, mon_e.rdata, mon_e.hit, mon_e.irq);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be; we = 1'b1;
    step();
    we = 1'b0; byteen = 4'h0;
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] er,
                    input logic eh, input logic ei);
    addr = a;
    exp_q.push_back({er, eh, ei});
    name_q.push_back(n);
    smp = 1'b1;
    step();
    smp = 1'b0;
  endtask

  // Auto-reload, PRESET=2: COUNT and irq after each edge from the CTRL write.
  logic [31:0] ar_cnt [14] = '{0, 2, 1, 0, 0, 2, 1, 0, 0, 2, 1, 0, 0, 2};
  logic        ar_irq [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rd("rst_ctrl",   A_CTRL,   32'h0, 1'b1, 1'b0);
    rd("rst_preset", A_PRESET, 32'h0, 1'b1, 1'b0);
    rd("rst_count",  A_COUNT,  32'h0, 1'b1, 1'b0);

    // Reset mid-count
    wr(A_PRESET, 32'd10, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    repeat (4) step();
    rd("mid_count_before_rst", A_COUNT, 32'd7, 1'b1, 1'b0);
    reset = 1'b1;
    rd("mid_rst_count",  A_COUNT,  32'h0, 1'b1, 1'b0);
    rd("mid_rst_ctrl",   A_CTRL,   32'h0, 1'b1, 1'b0);
    rd("mid_rst_preset", A_PRESET, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;
    rd("mid_rst_idle",   A_COUNT,  32'h0, 1'b1, 1'b0);

    // One-shot with interrupt
    wr(A_PRESET, 32'd3, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    rd("os_e0", A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("os_e1", A_COUNT, 32'd3, 1'b1, 1'b0);
    rd("os_e2", A_COUNT, 32'd2, 1'b1, 1'b0);
    rd("os_e3", A_COUNT, 32'd1, 1'b1, 1'b0);
    rd("os_e4", A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("os_e5_ctrl", A_CTRL, 32'h8, 1'b1, 1'b1);
    rd("os_e6_hold", A_CTRL, 32'h8, 1'b1, 1'b1);
    wr(A_CTRL, 32'h0, 4'hF);
    rd("os_irq_clr", A_CTRL, 32'h0, 1'b1, 1'b0);

    // PRESET=0: irq after edge 3
    wr(A_PRESET, 32'd0, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    rd("p0_e0", A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("p0_e1", A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("p0_e2", A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("p0_e3", A_CTRL,  32'h8, 1'b1, 1'b1);
    wr(A_CTRL, 32'h0, 4'hF);

    // Auto-reload
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int i = 0; i < 14; i++) begin
      rd($sformatf("ar_e%0d", i), A_COUNT, ar_cnt[i], 1'b1, ar_irq[i]);
    end
    wr(A_CTRL, 32'h0, 4'hF);
    rd("ar_stop_ctrl",  A_CTRL,  32'h0, 1'b1, 1'b0);
    rd("ar_stop_count", A_COUNT, 32'd1, 1'b1, 1'b0);

    // Masked interrupt
    wr(A_PRESET, 32'd1, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    rd("mask_e0", A_COUNT, 32'd1, 1'b1, 1'b0);
    rd("mask_e1", A_COUNT, 32'd1, 1'b1, 1'b0);
    rd("mask_e2", A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("mask_en_clr", A_CTRL, 32'h0, 1'b1, 1'b0);
    wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
    rd("count_ro",   A_COUNT,       32'h0, 1'b1, 1'b0);
    rd("rsv_read",   A_RSV,         32'h0, 1'b1, 1'b0);
    rd("nohit_10",   BASE + 32'h10, 32'h0, 1'b0, 1'b0);
    rd("nohit_8f00", 32'h0000_8F00, 32'h0, 1'b0, 1'b0);

    // CTRL upper bits and byte lanes
    wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
    rd("ctrl_upper_zero", A_CTRL, 32'h8, 1'b1, 1'b0);
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_PRESET, 32'h1122_3344, 4'hF);
    wr(A_PRESET, 32'hAABB_CCDD, 4'b0100);
    rd("preset_lane2", A_PRESET, EXP_LANE_PRESET, 1'b1, 1'b0);
    wr(A_PRESET, 32'hDEAD_BEEF, 4'b0000);
    rd("preset_be0", A_PRESET, EXP_LANE_PRESET, 1'b1, 1'b0);
    wr(A_CTRL, 32'h0000_0008, 4'b0010);
    rd("ctrl_lane1", A_CTRL, EXP_LANE_CTRL, 1'b1, 1'b0);
    wr(A_CTRL, 32'h0, 4'hF);

    // Software CTRL write colliding with the one-shot INT cycle
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    rd("col_e0", A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("col_e1", A_COUNT, 32'd2, 1'b1, 1'b0);
    rd("col_e2", A_COUNT, 32'd1, 1'b1, 1'b0);
    wr(A_CTRL, 32'h9, 4'hF);
    rd("col_ctrl_kept", A_CTRL,  32'h9, 1'b1, 1'b0);
    rd("col_load",      A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("col_reload",    A_COUNT, 32'd2, 1'b1, 1'b0);
    rd("col_dec",       A_COUNT, 32'd1, 1'b1, 1'b0);
    rd("col_zero",      A_COUNT, 32'd0, 1'b1, 1'b0);
    rd("col_irq",       A_CTRL,  32'h8, 1'b1, 1'b1);
    wr(A_CTRL, 32'h0, 4'hF);

    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
